// File: rtl/ticsat_ctrl.sv
// ticsat_ctrl: tile-job sequencer for one TicSAT systolic array
// Ports: clk/resetn (async active-low); start/abort/n_vec job control; busy/done status;
//        w_* weight stream in, a_* activation stream in, r_* result stream out;
//        sat_in_val/sat_in_idx/sat_cmd drive the array, sat_out is its result port.
package TicSAT_pkg;
   typedef enum logic [2:0] {
      CMD_NOP,
      CMD_LOAD_WEIGHT,
      CMD_PUSH_INPUT,
      CMD_STEP,
      CMD_READ_OUTPUT
   } command_t;
endpackage

module ticsat_ctrl
   import TicSAT_pkg::*;
#(
   parameter int SA_SIZE     = 4,
   parameter int DATA_W      = 8,
   parameter int VEC_W       = 8,
   parameter int DRAIN_STEPS = 7
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       start,
   input  logic                       abort,
   input  logic [VEC_W-1:0]           n_vec,
   output logic                       busy,
   output logic                       done,
   input  logic                       w_valid,
   output logic                       w_ready,
   input  logic [DATA_W-1:0]          w_data,
   input  logic                       a_valid,
   output logic                       a_ready,
   input  logic [DATA_W-1:0]          a_data,
   output logic                       r_valid,
   input  logic                       r_ready,
   output logic [DATA_W-1:0]          r_data,
   output logic [DATA_W-1:0]          sat_in_val,
   output logic [$clog2(SA_SIZE)-1:0] sat_in_idx,
   output command_t                   sat_cmd,
   input  logic [DATA_W-1:0]          sat_out
);
   localparam int IW  = $clog2(SA_SIZE);
   localparam int NW  = SA_SIZE * SA_SIZE;
   localparam int WW  = $clog2(NW);
   localparam int DCW = $clog2(DRAIN_STEPS + 1);

   typedef enum logic [2:0] {IDLE, LOAD_W, FEED, STEP, READ, DRAIN, FIN} state_t;

   state_t            state, state_d;
   logic [WW-1:0]     wcnt, wcnt_d;
   logic [IW-1:0]     ecnt, ecnt_d;
   logic [IW-1:0]     rcnt, rcnt_d;
   logic [VEC_W-1:0]  vcnt, vcnt_d;
   logic [VEC_W-1:0]  nv, nv_d;
   logic [DCW-1:0]    dcnt, dcnt_d;
   logic              rd_pend, rd_pend_d;
   logic              r_valid_d;
   logic [DATA_W-1:0] r_data_d;
   logic [DATA_W-1:0] sat_in_val_d;
   logic [IW-1:0]     sat_in_idx_d;
   command_t          sat_cmd_d;

   assign busy    = (state != IDLE) && (state != FIN);
   assign done    = (state == FIN);
   assign w_ready = (state == LOAD_W);
   assign a_ready = (state == FEED);

   always_comb begin
      state_d      = state;
      wcnt_d       = wcnt;
      ecnt_d       = ecnt;
      rcnt_d       = rcnt;
      vcnt_d       = vcnt;
      nv_d         = nv;
      dcnt_d       = dcnt;
      rd_pend_d    = 1'b0;
      r_valid_d    = r_valid;
      r_data_d     = r_data;
      sat_cmd_d    = CMD_NOP;
      sat_in_val_d = '0;
      sat_in_idx_d = '0;
      // the read issued last cycle is on the array pins now, so its result is sampled here
      if (rd_pend) begin
         r_data_d  = sat_out;
         r_valid_d = 1'b1;
      end
      if (r_valid && r_ready) r_valid_d = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_d = LOAD_W;
               nv_d    = n_vec;
               wcnt_d  = '0;
               ecnt_d  = '0;
               rcnt_d  = '0;
               vcnt_d  = '0;
               dcnt_d  = '0;
            end
         end
         LOAD_W: begin
            if (w_valid) begin
               sat_cmd_d    = CMD_LOAD_WEIGHT;
               sat_in_val_d = w_data;
               sat_in_idx_d = IW'(wcnt % WW'(SA_SIZE));
               wcnt_d       = wcnt + 1'b1;
               if (wcnt == WW'(NW - 1)) begin
                  wcnt_d  = '0;
                  state_d = (nv != '0) ? FEED : DRAIN;
               end
            end
         end
         FEED: begin
            if (a_valid) begin
               sat_cmd_d    = CMD_PUSH_INPUT;
               sat_in_val_d = a_data;
               sat_in_idx_d = ecnt;
               ecnt_d       = ecnt + 1'b1;
               if (ecnt == IW'(SA_SIZE - 1)) begin
                  ecnt_d  = '0;
                  vcnt_d  = vcnt + 1'b1;
                  state_d = STEP;
               end
            end
         end
         DRAIN: begin
            sat_cmd_d    = CMD_PUSH_INPUT;
            sat_in_idx_d = ecnt;
            ecnt_d       = ecnt + 1'b1;
            if (ecnt == IW'(SA_SIZE - 1)) begin
               ecnt_d  = '0;
               dcnt_d  = dcnt + 1'b1;
               state_d = STEP;
            end
         end
         STEP: begin
            sat_cmd_d = CMD_STEP;
            state_d   = READ;
         end
         READ: begin
            // one read in flight at a time; the next waits until the consumer takes the result
            if (!r_valid && !rd_pend) begin
               sat_cmd_d    = CMD_READ_OUTPUT;
               sat_in_idx_d = rcnt;
               rcnt_d       = (rcnt == IW'(SA_SIZE - 1)) ? '0 : rcnt + 1'b1;
               rd_pend_d    = 1'b1;
            end
            // rcnt has wrapped once the last index was issued, so a handshake at rcnt==0 ends the round
            if (r_valid && r_ready && rcnt == '0)
               state_d = (vcnt < nv) ? FEED : (dcnt < DCW'(DRAIN_STEPS)) ? DRAIN : FIN;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && state != IDLE) begin
         state_d      = IDLE;
         sat_cmd_d    = CMD_NOP;
         sat_in_val_d = '0;
         sat_in_idx_d = '0;
         r_valid_d    = 1'b0;
         rd_pend_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         wcnt       <= '0;
         ecnt       <= '0;
         rcnt       <= '0;
         vcnt       <= '0;
         nv         <= '0;
         dcnt       <= '0;
         rd_pend    <= 1'b0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         sat_cmd    <= CMD_NOP;
         sat_in_val <= '0;
         sat_in_idx <= '0;
      end else begin
         state      <= state_d;
         wcnt       <= wcnt_d;
         ecnt       <= ecnt_d;
         rcnt       <= rcnt_d;
         vcnt       <= vcnt_d;
         nv         <= nv_d;
         dcnt       <= dcnt_d;
         rd_pend    <= rd_pend_d;
         r_valid    <= r_valid_d;
         r_data     <= r_data_d;
         sat_cmd    <= sat_cmd_d;
         sat_in_val <= sat_in_val_d;
         sat_in_idx <= sat_in_idx_d;
      end
   end
endmodule
